// File: rtl/fir_mac_sequencer.sv
// Sequences one shared signed MAC across all FIR taps, one tap per clock.
// Owns the sample delay line and the coefficient ROM address; emits one result per start.
module fir_mac_sequencer #(
    parameter int cant_bits = 25,
    parameter int taps      = 8,
    parameter int addr_bits = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [cant_bits-1:0]   x_in,
    output logic        [addr_bits-1:0]   coef_addr,
    input  logic signed [cant_bits-1:0]   coef_in,
    output logic signed [cant_bits-1:0]   mac_in,
    output logic signed [cant_bits-1:0]   mac_cte,
    output logic signed [2*cant_bits-2:0] mac_acum,
    input  logic signed [2*cant_bits-2:0] mac_out,
    output logic signed [2*cant_bits-2:0] y_out,
    output logic                          y_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam logic [addr_bits-1:0] last_k = addr_bits'(taps - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        [addr_bits-1:0]   k;
    logic signed [2*cant_bits-2:0] acc;
    logic signed [cant_bits-1:0]   dline [taps];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // MAC operands are forced to zero outside MAC so the idle MAC output is zero.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        mac_in    = '0;
        mac_acum  = '0;
        mac_cte   = coef_in;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                busy     = 1'b1;
                mac_in   = dline[k];
                mac_acum = acc;
                if (k == last_k) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k         <= '0;
            acc       <= '0;
            coef_addr <= '0;
            y_out     <= '0;
            y_valid   <= 1'b0;
            overrun   <= 1'b0;
            for (int unsigned i = 0; i < taps; i++) begin
                dline[i] <= '0;
            end
        end else begin
            y_valid <= 1'b0;
            overrun <= start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 1; i < taps; i++) begin
                            dline[i] <= dline[i-1];
                        end
                        dline[0]  <= x_in;
                        acc       <= '0;
                        k         <= '0;
                        coef_addr <= '0;
                    end
                end
                MAC: begin
                    acc <= mac_out;
                    if (k == last_k) begin
                        k         <= '0;
                        coef_addr <= '0;
                    end else begin
                        k         <= k + addr_bits'(1);
                        coef_addr <= k + addr_bits'(1);
                    end
                end
                DONE: begin
                    y_out   <= acc;
                    y_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer (4 taps) with a behavioural MAC, ROM
// and a dot-product reference model over the accepted-sample history.
module tb_fir_mac_sequencer;

    localparam int CB = 25;
    localparam int AW = 2 * CB - 1;
    localparam int NT = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic signed [CB-1:0] x_in;
    logic        [1:0]    coef_addr;
    logic signed [CB-1:0] coef_in;
    logic signed [CB-1:0] mac_in;
    logic signed [CB-1:0] mac_cte;
    logic signed [AW-1:0] mac_acum;
    logic signed [AW-1:0] mac_out;
    logic signed [AW-1:0] y_out;
    logic                 y_valid;
    logic                 busy;
    logic                 overrun;

    logic signed [CB-1:0] coefs [NT];
    logic signed [CB-1:0] hist  [NT];
    logic signed [AW-1:0] ext_a;
    logic signed [AW-1:0] ext_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer #(
        .cant_bits(CB),
        .taps     (NT),
        .addr_bits(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x_in     (x_in),
        .coef_addr(coef_addr),
        .coef_in  (coef_in),
        .mac_in   (mac_in),
        .mac_cte  (mac_cte),
        .mac_acum (mac_acum),
        .mac_out  (mac_out),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    // External combinational ROM and MAC unit.
    assign coef_in = coefs[coef_addr];
    always_comb begin
        ext_a   = AW'(mac_cte);
        ext_b   = AW'(mac_in);
        mac_out = ext_a * ext_b + mac_acum;
    end

    function automatic logic signed [AW-1:0] model_y();
        longint s = 0;
        for (int i = 0; i < NT; i++) s += longint'(coefs[i]) * longint'(hist[i]);
        return s[AW-1:0];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NT; i++) hist[i] = '0;
    endtask

    // Issues one start and waits (bounded) for y_valid; lat counts edges from acceptance.
    task automatic do_sample(input logic signed [CB-1:0] x, output logic signed [AW-1:0] y,
                             output int lat);
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        for (int i = NT - 1; i >= 1; i--) hist[i] = hist[i-1];
        hist[0] = x;
        while (y_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        y = y_out;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        x_in  = '0;
        apply_reset();
        #1;
        checks++; if (coef_addr !== 2'd0) begin errors++; $display("FAIL reset_coef_addr got %0d exp 0", coef_addr); end
        checks++; if (y_out !== '0) begin errors++; $display("FAIL reset_y_out got %0d exp 0", y_out); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got %b exp 0", y_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (mac_in !== '0 || mac_acum !== '0) begin errors++; $display("FAIL reset_mac_idle got in=%0d acum=%0d exp 0", mac_in, mac_acum); end
    endtask

    task automatic test_impulse();
        logic signed [AW-1:0] y;
        int lat;
        logic signed [CB-1:0] xs [NT];
        xs[0] = 1; xs[1] = 0; xs[2] = 0; xs[3] = 0;
        coefs[0] = 1; coefs[1] = 2; coefs[2] = 3; coefs[3] = 4;
        apply_reset();
        for (int i = 0; i < NT; i++) begin
            do_sample(xs[i], y, lat);
            checks++; if (y !== AW'(i + 1)) begin errors++; $display("FAIL impulse_y[%0d] got %0d exp %0d", i, y, i + 1); end
            checks++; if (lat !== 6) begin errors++; $display("FAIL impulse_latency[%0d] got %0d exp 6", i, lat); end
        end
    endtask

    task automatic test_step();
        logic signed [AW-1:0] y;
        logic signed [AW-1:0] exp_y [NT];
        int lat;
        exp_y[0] = 100; exp_y[1] = 300; exp_y[2] = 600; exp_y[3] = 1000;
        apply_reset();
        for (int i = 0; i < NT; i++) begin
            do_sample(25'sd100, y, lat);
            checks++; if (y !== exp_y[i]) begin errors++; $display("FAIL step_y[%0d] got %0d exp %0d", i, y, exp_y[i]); end
        end
    endtask

    task automatic test_signed();
        logic signed [AW-1:0] y;
        int lat;
        coefs[0] = -3; coefs[1] = 2; coefs[2] = 0; coefs[3] = -1;
        apply_reset();
        do_sample(-25'sd5, y, lat);
        checks++; if (y !== 49'sd15) begin errors++; $display("FAIL signed_y0 got %0d exp 15", y); end
        do_sample(25'sd7, y, lat);
        checks++; if (y !== -49'sd31) begin errors++; $display("FAIL signed_y1 got %0d exp -31", y); end
    endtask

    task automatic test_extreme();
        logic signed [AW-1:0] y;
        logic signed [AW-1:0] m;
        int lat;
        for (int i = 0; i < NT; i++) coefs[i] = -(25'sd1 <<< 24);
        apply_reset();
        for (int i = 0; i < NT; i++) begin
            do_sample(-(25'sd1 <<< 24), y, lat);
            m = model_y();
            checks++; if (y !== m) begin errors++; $display("FAIL extreme_y[%0d] got %0d exp %0d", i, y, m); end
        end
        checks++; if (y !== '0) begin errors++; $display("FAIL extreme_wrap got %0d exp 0", y); end
    endtask

    task automatic test_overrun();
        logic signed [AW-1:0] y;
        logic signed [AW-1:0] m;
        int lat;
        coefs[0] = 1; coefs[1] = 2; coefs[2] = 3; coefs[3] = 4;
        apply_reset();
        @(negedge clk);
        start = 1'b1;
        x_in  = 25'sd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        hist[0] = 25'sd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        x_in  = 25'sd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got %b exp 1", overrun); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy got %b exp 1", busy); end
        @(posedge clk);
        #1;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_one_cycle got %b exp 0", overrun); end
        lat = 4;
        while (y_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat !== 6) begin errors++; $display("FAIL overrun_latency got %0d exp 6", lat); end
        checks++; if (y_out !== 49'sd5) begin errors++; $display("FAIL overrun_first_y got %0d exp 5", y_out); end
        do_sample(25'sd1, y, lat);
        m = model_y();
        checks++; if (y !== m || y !== 49'sd11) begin errors++; $display("FAIL overrun_dropped got %0d exp %0d", y, m); end
    endtask

    task automatic test_reset_mid();
        logic signed [AW-1:0] y;
        int lat;
        int seen;
        coefs[0] = 1; coefs[1] = 2; coefs[2] = 3; coefs[3] = 4;
        apply_reset();
        do_sample(25'sd77, y, lat);
        @(negedge clk);
        start = 1'b1;
        x_in  = 25'sd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (coef_addr !== 2'd2) begin errors++; $display("FAIL midreset_k got %0d exp 2", coef_addr); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NT; i++) hist[i] = '0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (y_valid === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        checks++; if (seen !== 0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_abort got valids=%0d busy=%b exp 0,0", seen, busy); end
        do_sample(25'sd1, y, lat);
        checks++; if (y !== 49'sd1) begin errors++; $display("FAIL midreset_cleared got %0d exp 1", y); end
    endtask

    task automatic test_back_to_back_random();
        logic signed [AW-1:0] y;
        logic signed [AW-1:0] m;
        int lat;
        for (int i = 0; i < NT; i++) coefs[i] = CB'($urandom);
        apply_reset();
        for (int n = 0; n < 24; n++) begin
            do_sample(CB'($urandom), y, lat);
            m = model_y();
            checks++; if (y !== m) begin errors++; $display("FAIL random_y[%0d] got %0d exp %0d", n, y, m); end
            checks++; if (lat !== 6) begin errors++; $display("FAIL random_latency[%0d] got %0d exp 6", n, lat); end
        end
        @(posedge clk);
        #1;
        checks++; if (mac_in !== '0 || mac_acum !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL random_idle got in=%0d acum=%0d busy=%b exp 0", mac_in, mac_acum, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < NT; i++) begin
            coefs[i] = '0;
            hist[i]  = '0;
        end
        test_reset();
        test_impulse();
        test_step();
        test_signed();
        test_extreme();
        test_overrun();
        test_reset_mid();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
